// File: rtl/aquarium_pkg.sv
// Shared state encoding and widths for the aquarium controller, pump sequencer and display path.
// Constants only; no latency or flow control.
package aquarium_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRIME    = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_COOLDOWN = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    localparam int RUN_COUNT_W = 8;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PRIME    = ST_PRIME,
        RUN      = ST_RUN,
        COOLDOWN = ST_COOLDOWN,
        FAULT    = ST_FAULT
    } pump_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pump_sequencer_tick_gen.sv
// Free-running divider: one-clk tick when the count reaches TICK_DIV-1; combinational from the count.
// No backpressure; runs every cycle regardless of consumers.
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pump_sequencer.sv
// Valve/pump start-up sequencer with min on/off times, tank_full hard stop and run watchdog; outputs one clk after inputs.
// No backpressure: request is a level, sampled every clk.
module pump_sequencer
    import aquarium_pkg::*;
#(
    parameter int TICK_DIV      = 1000,
    parameter int PRIME_TICKS   = 3,
    parameter int MIN_ON_TICKS  = 10,
    parameter int MIN_OFF_TICKS = 20,
    parameter int MAX_RUN_TICKS = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pump_request,
    input  logic                   tank_full,
    input  logic                   fault_clear,
    output logic                   valve_open,
    output logic                   pump_enable,
    output logic                   fault,
    output logic [2:0]             state_code,
    output logic [RUN_COUNT_W-1:0] run_count
);

    localparam int MAXP = max4(PRIME_TICKS, MIN_ON_TICKS, MIN_OFF_TICKS, MAX_RUN_TICKS);
    localparam int TW   = $clog2(MAXP + 1);

    localparam logic [TW-1:0] T_PRIME   = TW'(PRIME_TICKS);
    localparam logic [TW-1:0] T_MIN_ON  = TW'(MIN_ON_TICKS);
    localparam logic [TW-1:0] T_MIN_OFF = TW'(MIN_OFF_TICKS);
    localparam logic [TW-1:0] T_MAX_RUN = TW'(MAX_RUN_TICKS);

    pump_state_t   state_q, state_d;
    logic [TW-1:0] timer;
    logic          tick;
    logic          valve_d, pump_d, fault_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pump_request && !tank_full) state_d = PRIME;
            end
            PRIME: begin
                if (tank_full || !pump_request) state_d = IDLE;
                else if (timer == T_PRIME)      state_d = RUN;
            end
            RUN: begin
                // tank_full outranks both the watchdog and the min-on hold
                if (tank_full)                                 state_d = COOLDOWN;
                else if (timer == T_MAX_RUN)                   state_d = FAULT;
                else if (!pump_request && timer >= T_MIN_ON)   state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (timer == T_MIN_OFF) state_d = IDLE;
            end
            FAULT: begin
                if (fault_clear && !pump_request) state_d = COOLDOWN;
            end
            default: state_d = IDLE;
        endcase

        valve_d = (state_d == PRIME) || (state_d == RUN);
        pump_d  = (state_d == RUN);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valve_open  <= 1'b0;
            pump_enable <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            valve_open  <= valve_d;
            pump_enable <= pump_d;
            fault       <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state_d != state_q) begin
            timer <= '0;
        end else if (tick && (timer != '1)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_count <= '0;
        end else if ((state_q == PRIME) && (state_d == RUN) && (run_count != '1)) begin
            run_count <= run_count + 1'b1;
        end
    end

    assign state_code = state_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed bench for pump_sequencer with TICK_DIV=4 PRIME=1 MIN_ON=2 MIN_OFF=3 MAX_RUN=8.
// Edge numbers in comments count posedges after a tick-aligned start (ticks land on E4, E8, ...).
module tb_pump_sequencer;

    logic       clk;
    logic       rst;
    logic       pump_request;
    logic       tank_full;
    logic       fault_clear;
    logic       valve_open;
    logic       pump_enable;
    logic       fault;
    logic [2:0] state_code;
    logic [7:0] run_count;

    int vectors;
    int errors;
    int cyc;

    pump_sequencer #(
        .TICK_DIV      (4),
        .PRIME_TICKS   (1),
        .MIN_ON_TICKS  (2),
        .MIN_OFF_TICKS (3),
        .MAX_RUN_TICKS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pump_request (pump_request),
        .tank_full    (tank_full),
        .fault_clear  (fault_clear),
        .valve_open   (valve_open),
        .pump_enable  (pump_enable),
        .fault        (fault),
        .state_code   (state_code),
        .run_count    (run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the divider phase equals cyc % 4.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        int guard;
        guard = 0;
        while ((cyc % 4) != 0 && guard < 8) begin
            step(1);
            guard++;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input int code, input int budget);
        int n;
        n = 0;
        while (int'(state_code) != code && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, int'(state_code), code);
    endtask

    initial begin
        vectors      = 0;
        errors       = 0;
        rst          = 1'b1;
        pump_request = 1'b0;
        tank_full    = 1'b0;
        fault_clear  = 1'b0;
        step(3);

        chk("reset valve", int'(valve_open), 0);
        chk("reset pump", int'(pump_enable), 0);
        chk("reset fault", int'(fault), 0);
        chk("reset state", int'(state_code), 0);
        chk("reset run_count", int'(run_count), 0);
        rst = 1'b0;

        // 1: held request runs into the watchdog
        pump_request = 1'b1;
        step(1);                                       // E1
        chk("t1 valve after E1", int'(valve_open), 1);
        chk("t1 pump after E1", int'(pump_enable), 0);
        chk("t1 state PRIME", int'(state_code), 1);
        step(3);                                       // E4: timer=1
        chk("t1 pump still off E4", int'(pump_enable), 0);
        step(1);                                       // E5: RUN
        chk("t1 state RUN", int'(state_code), 2);
        chk("t1 pump on", int'(pump_enable), 1);
        chk("t1 valve on", int'(valve_open), 1);
        chk("t1 run_count", int'(run_count), 1);
        step(31);                                      // E36: timer=8
        chk("t1 still RUN E36", int'(state_code), 2);
        step(1);                                       // E37
        chk("t1 state FAULT", int'(state_code), 4);
        chk("t1 fault", int'(fault), 1);
        chk("t1 pump off at fault", int'(pump_enable), 0);
        chk("t1 valve off at fault", int'(valve_open), 0);

        // 5: fault_clear only honoured with request low
        fault_clear = 1'b1;
        step(1);
        chk("t5 clear ignored state", int'(state_code), 4);
        chk("t5 clear ignored fault", int'(fault), 1);
        pump_request = 1'b0;
        step(1);
        fault_clear = 1'b0;
        chk("t5 cleared state", int'(state_code), 3);
        chk("t5 cleared fault", int'(fault), 0);
        wait_state("t5 back to IDLE", 0, 40);

        // 2: sub-tick pulse aborts PRIME
        align();
        pump_request = 1'b1;
        step(1);                                       // E1
        chk("t2 PRIME", int'(state_code), 1);
        chk("t2 valve", int'(valve_open), 1);
        pump_request = 1'b0;
        step(1);                                       // E2
        chk("t2 IDLE", int'(state_code), 0);
        chk("t2 valve off", int'(valve_open), 0);
        chk("t2 pump off", int'(pump_enable), 0);
        chk("t2 run_count", int'(run_count), 1);

        // 3: early drop held to min-on, then cooldown ignores requests
        align();
        pump_request = 1'b1;
        step(5);                                       // E5: RUN
        chk("t3 RUN", int'(state_code), 2);
        chk("t3 run_count", int'(run_count), 2);
        step(3);                                       // E8: timer=1
        pump_request = 1'b0;
        step(1);                                       // E9
        chk("t3 min-on hold E9", int'(pump_enable), 1);
        step(3);                                       // E12: timer=2
        chk("t3 min-on hold E12", int'(pump_enable), 1);
        chk("t3 state E12", int'(state_code), 2);
        step(1);                                       // E13
        chk("t3 COOLDOWN", int'(state_code), 3);
        chk("t3 pump off", int'(pump_enable), 0);
        chk("t3 valve off", int'(valve_open), 0);
        step(1);                                       // E14
        pump_request = 1'b1;
        step(6);                                       // E20
        chk("t3 request ignored E20", int'(state_code), 3);
        chk("t3 valve stays off", int'(valve_open), 0);
        step(3);                                       // E23
        pump_request = 1'b0;
        step(1);                                       // E24: timer=3
        chk("t3 still COOLDOWN E24", int'(state_code), 3);
        step(1);                                       // E25
        chk("t3 IDLE after cooldown", int'(state_code), 0);

        // 4a: tank_full at RUN timer=1
        align();
        pump_request = 1'b1;
        step(8);                                       // E8: RUN, timer=1
        chk("t4 run_count", int'(run_count), 3);
        tank_full = 1'b1;
        step(1);                                       // E9
        chk("t4 state COOLDOWN", int'(state_code), 3);
        chk("t4 pump off", int'(pump_enable), 0);
        chk("t4 valve off", int'(valve_open), 0);
        tank_full    = 1'b0;
        pump_request = 1'b0;
        wait_state("t4 back to IDLE", 0, 40);

        // 4b: tank_full coincides with max-run
        align();
        pump_request = 1'b1;
        step(36);                                      // E36: timer=8
        chk("t4b RUN at max", int'(state_code), 2);
        tank_full = 1'b1;
        step(1);                                       // E37
        chk("t4b state COOLDOWN", int'(state_code), 3);
        chk("t4b no fault", int'(fault), 0);
        tank_full    = 1'b0;
        pump_request = 1'b0;
        wait_state("t4b back to IDLE", 0, 40);

        // 6: reset mid-RUN
        align();
        pump_request = 1'b1;
        step(6);                                       // E6: RUN
        chk("t6 pump before rst", int'(pump_enable), 1);
        rst = 1'b1;
        step(1);
        chk("t6 valve", int'(valve_open), 0);
        chk("t6 pump", int'(pump_enable), 0);
        chk("t6 fault", int'(fault), 0);
        chk("t6 state", int'(state_code), 0);
        chk("t6 run_count", int'(run_count), 0);
        rst          = 1'b0;
        pump_request = 1'b0;
        step(1);

        // 6b: 256 short runs saturate run_count
        for (int i = 0; i < 256; i++) begin
            pump_request = 1'b1;
            wait_state("sat reach RUN", 2, 20);
            pump_request = 1'b0;
            tank_full    = 1'b1;
            step(1);
            tank_full = 1'b0;
            wait_state("sat reach IDLE", 0, 30);
            if (i == 253) chk("sat run_count 254", int'(run_count), 254);
            if (i == 254) chk("sat run_count 255", int'(run_count), 255);
        end
        chk("sat run_count held", int'(run_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
